// File: rtl/fpga_keypad_reader_pkg.sv
// Shared types and constants for the 4x4 keypad reader peripheral.
package keypad_pkg;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD} kp_state_t;
  typedef enum logic [1:0] {SCAN_NONE, SCAN_ONE, SCAN_MULTI} kp_scan_t;

  localparam int         KP_DEPTH      = 4;
  localparam logic [7:0] KP_EMPTY_READ = 8'hFF;

  // Bit positions inside the STATUS register; count occupies three bits from STAT_COUNT_LSB.
  localparam int STAT_NOT_EMPTY = 0;
  localparam int STAT_OVERFLOW  = 1;
  localparam int STAT_COUNT_LSB = 2;

endpackage

// File: rtl/fpga_keypad_reader_if.sv
// CPU read bus between the processor (master) and the keypad peripheral (slave).
interface fpga_keypad_reader_if;

  logic [7:0] addressbusHigh;
  logic [7:0] addressbusLow;
  logic       readEnable;
  logic [7:0] dataOut;
  logic       dataDrive;

  modport master (output addressbusHigh, addressbusLow, readEnable,
                  input  dataOut, dataDrive);
  modport slave  (input  addressbusHigh, addressbusLow, readEnable,
                  output dataOut, dataDrive);

endinterface

// File: rtl/fpga_keypad_reader_fifo.sv
// Four-entry queue of 4-bit key codes; a push into a full queue is refused unless a pop frees a slot.
module keypad_fifo
  import keypad_pkg::*;
(
  input  logic       clk_i,
  input  logic       nrst_i,
  input  logic       push_i,
  input  logic [3:0] pushData_i,
  input  logic       pop_i,
  output logic [3:0] head_o,
  output logic [2:0] count_o,
  output logic       full_o,
  output logic       empty_o
);

  logic [3:0] mem_q [KP_DEPTH];
  logic [1:0] wrPtr_q, rdPtr_q;
  logic [2:0] count_q, count_d;
  logic       doPush, doPop;

  assign empty_o = (count_q == 3'd0);
  assign full_o  = (count_q == 3'(KP_DEPTH));
  assign doPop   = pop_i && !empty_o;
  assign doPush  = push_i && (!full_o || doPop);
  assign head_o  = mem_q[rdPtr_q];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (doPush && !doPop) begin
      count_d = count_q + 3'd1;
    end else if (doPop && !doPush) begin
      count_d = count_q - 3'd1;
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      for (int i = 0; i < KP_DEPTH; i++) mem_q[i] <= '0;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        mem_q[wrPtr_q] <= pushData_i;
        wrPtr_q        <= wrPtr_q + 2'd1;
      end
      if (doPop) rdPtr_q <= rdPtr_q + 2'd1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fpga_keypad_reader.sv
// Memory-mapped 4x4 keypad reader: column scanner, scan-level debounce FSM, code FIFO
// and DATA/STATUS read decode on the CPU bus.
module fpga_keypad_reader
  import keypad_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR      = 16'h0008,
  parameter int          SCAN_DIV       = 250,
  parameter int          DEBOUNCE_SCANS = 4
) (
  input  logic                 clk_i,
  input  logic                 nrst_i,
  input  logic [3:0]           rowIn_i,
  output logic [3:0]           colOut_o,
  fpga_keypad_reader_if.slave  bus
);

  localparam int               DIV_W    = $clog2(SCAN_DIV);
  localparam int               DBC_W    = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DBC_W-1:0] DBC_DONE = DBC_W'(DEBOUNCE_SCANS);

  logic [3:0]       sync1_q, sync2_q;
  logic [DIV_W-1:0] divCnt_q;
  logic [1:0]       colIdx_q;
  logic [1:0]       hitAcc_q, hitAcc_d;
  logic [3:0]       codeAcc_q, codeAcc_d;
  logic             slotEnd, scanEnd;
  logic [3:0]       rowsLow;
  logic [2:0]       colHits;
  logic [1:0]       colRow;
  logic [3:0]       scanHits;
  logic [3:0]       scanCode;
  kp_scan_t         scanResult;

  kp_state_t        state_q, state_d;
  logic [DBC_W-1:0] dbc_q, dbc_d;
  logic [3:0]       cand_q, cand_d;
  logic             push;
  logic [3:0]       pushCode;

  logic [15:0]      addr;
  logic             hitData, hitStatus, pop;
  logic             overflow_q, overflow_d;
  logic [3:0]       head;
  logic [2:0]       count;
  logic             full, empty;
  logic [7:0]       statusByte;

  assign slotEnd  = (divCnt_q == DIV_LAST);
  assign scanEnd  = slotEnd && (colIdx_q == 2'd3);
  assign rowsLow  = ~sync2_q;
  assign colOut_o = ~(4'b0001 << colIdx_q);

  // Hits are accumulated column by column (saturating at 2); the code is kept from the first hit only.
  always_comb begin
    colHits = '0;
    colRow  = '0;
    for (int r = 3; r >= 0; r--) begin
      if (rowsLow[r]) begin
        colHits = colHits + 3'd1;
        colRow  = 2'(r);
      end
    end
    scanHits  = {2'b00, hitAcc_q} + {1'b0, colHits};
    scanCode  = (hitAcc_q == 2'd0) ? {colRow, colIdx_q} : codeAcc_q;
    hitAcc_d  = hitAcc_q;
    codeAcc_d = codeAcc_q;
    if (slotEnd) begin
      hitAcc_d  = scanEnd ? 2'd0 : ((scanHits > 4'd2) ? 2'd2 : scanHits[1:0]);
      codeAcc_d = scanEnd ? 4'd0 : scanCode;
    end
    if (scanHits == 4'd0)      scanResult = SCAN_NONE;
    else if (scanHits == 4'd1) scanResult = SCAN_ONE;
    else                       scanResult = SCAN_MULTI;
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      sync1_q   <= 4'hF;
      sync2_q   <= 4'hF;
      divCnt_q  <= '0;
      colIdx_q  <= '0;
      hitAcc_q  <= '0;
      codeAcc_q <= '0;
    end else begin
      sync1_q   <= rowIn_i;
      sync2_q   <= sync1_q;
      divCnt_q  <= slotEnd ? '0 : divCnt_q + DIV_W'(1);
      if (slotEnd) colIdx_q <= colIdx_q + 2'd1;
      hitAcc_q  <= hitAcc_d;
      codeAcc_q <= codeAcc_d;
    end
  end

  // Debounce runs once per full scan; a held key never re-pushes until it has been released.
  always_comb begin
    state_d  = state_q;
    dbc_d    = dbc_q;
    cand_d   = cand_q;
    push     = 1'b0;
    pushCode = cand_q;
    if (scanEnd) begin
      unique case (state_q)
        IDLE: begin
          if (scanResult == SCAN_ONE) begin
            cand_d   = scanCode;
            pushCode = scanCode;
            if (DEBOUNCE_SCANS == 1) begin
              push    = 1'b1;
              state_d = HELD;
              dbc_d   = '0;
            end else begin
              state_d = DEBOUNCE;
              dbc_d   = DBC_W'(1);
            end
          end
        end
        DEBOUNCE: begin
          if (scanResult == SCAN_ONE && scanCode == cand_q) begin
            if (dbc_q + DBC_W'(1) == DBC_DONE) begin
              push    = 1'b1;
              state_d = HELD;
              dbc_d   = '0;
            end else begin
              dbc_d = dbc_q + DBC_W'(1);
            end
          end else begin
            state_d = IDLE;
            dbc_d   = '0;
          end
        end
        HELD: begin
          if (scanResult == SCAN_NONE) begin
            if (dbc_q + DBC_W'(1) == DBC_DONE) begin
              state_d = IDLE;
              dbc_d   = '0;
            end else begin
              dbc_d = dbc_q + DBC_W'(1);
            end
          end else begin
            dbc_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q    <= IDLE;
      dbc_q      <= '0;
      cand_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dbc_q      <= dbc_d;
      cand_q     <= cand_d;
      overflow_q <= overflow_d;
    end
  end

  keypad_fifo u_fifo (
    .clk_i      (clk_i),
    .nrst_i     (nrst_i),
    .push_i     (push),
    .pushData_i (pushCode),
    .pop_i      (pop),
    .head_o     (head),
    .count_o    (count),
    .full_o     (full),
    .empty_o    (empty)
  );

  assign addr       = {bus.addressbusHigh, bus.addressbusLow};
  assign hitData    = bus.readEnable && (addr == BASE_ADDR);
  assign hitStatus  = bus.readEnable && (addr == BASE_ADDR + 16'd1);
  assign pop        = hitData && !empty;
  // A dropped push outranks a STATUS read clearing the flag in the same cycle.
  assign overflow_d = (push && full && !pop) ? 1'b1 : (hitStatus ? 1'b0 : overflow_q);

  always_comb begin
    statusByte                          = '0;
    statusByte[STAT_NOT_EMPTY]          = !empty;
    statusByte[STAT_OVERFLOW]           = overflow_q;
    statusByte[STAT_COUNT_LSB +: 3]     = count;
    bus.dataDrive = hitData || hitStatus;
    bus.dataOut   = 8'h00;
    if (hitData)        bus.dataOut = empty ? KP_EMPTY_READ : {4'b0000, head};
    else if (hitStatus) bus.dataOut = statusByte;
  end

endmodule

// File: tb/tb_fpga_keypad_reader.sv
// Randomised and directed checks of the keypad reader against a scan-level behavioural model.
`timescale 1ns/1ps
module tb_fpga_keypad_reader;

  localparam int          SCAN_DIV = 4;
  localparam int          DEB      = 2;
  localparam logic [15:0] BASE     = 16'h0008;
  localparam int          SCAN_CYC = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [3:0]  rowIn;
  logic [3:0]  colOut;
  logic [15:0] keyMask = '0;
  int          total = 0;
  int          bad = 0;
  int          cyc;

  logic [3:0]  mq[$];
  logic        mOvf;
  logic        mHeld;
  int          mStreak;
  int          mCode;

  fpga_keypad_reader_if bus ();

  fpga_keypad_reader #(
    .BASE_ADDR      (BASE),
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEB)
  ) dut (
    .clk_i    (clk),
    .nrst_i   (nrst),
    .rowIn_i  (rowIn),
    .colOut_o (colOut),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    rowIn = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!colOut[c] && keyMask[r*4+c]) rowIn[r] = 1'b0;
  end

  always @(posedge clk or negedge nrst) begin
    if (!nrst) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitScans(input int n);
    for (int i = 0; i < n; i++) begin
      do begin
        @(posedge clk);
        #1;
      end while (cyc % SCAN_CYC != 0);
    end
  endtask

  task automatic alignLastCycle();
    while (cyc % SCAN_CYC != SCAN_CYC - 1) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic busRead(input logic [15:0] addr, output logic [7:0] data, output logic drive);
    bus.addressbusHigh = addr[15:8];
    bus.addressbusLow  = addr[7:0];
    bus.readEnable     = 1'b1;
    @(negedge clk);
    data  = bus.dataOut;
    drive = bus.dataDrive;
    @(posedge clk);
    #1;
    bus.readEnable = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    nrst = 1'b0;
    keyMask = '0;
    bus.readEnable = 1'b0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic modelScan(input logic [15:0] mask);
    int n;
    int code;
    n = $countones(mask);
    code = 0;
    for (int i = 0; i < 16; i++) if (mask[i]) code = i;
    if (!mHeld) begin
      if (n == 1) begin
        if (mStreak == 0) begin
          mStreak = 1;
          mCode = code;
        end else if (code == mCode) begin
          mStreak++;
        end else begin
          mStreak = 0;
        end
        if (mStreak == DEB) begin
          if (mq.size() == 4) mOvf = 1'b1;
          else mq.push_back(4'(mCode));
          mHeld = 1'b1;
          mStreak = 0;
        end
      end else begin
        mStreak = 0;
      end
    end else begin
      if (n == 0) begin
        mStreak++;
        if (mStreak == DEB) begin
          mHeld = 1'b0;
          mStreak = 0;
        end
      end else begin
        mStreak = 0;
      end
    end
  endtask

  task automatic test_reset();
    bus.addressbusHigh = 8'h00;
    bus.addressbusLow  = 8'h08;
    bus.readEnable     = 1'b0;
    nrst = 1'b0;
    keyMask = '0;
    repeat (3) @(negedge clk);
    total++;
    if (colOut !== 4'b1110) begin bad++; $display("[TB] FAIL reset_col: got %b expected %b", colOut, 4'b1110); end
    total++;
    if (bus.dataDrive !== 1'b0 || bus.dataOut !== 8'h00) begin
      bad++; $display("[TB] FAIL reset_idle_bus: got drive=%b data=%h expected drive=0 data=00", bus.dataDrive, bus.dataOut);
    end
    bus.addressbusLow = 8'h09;
    bus.readEnable = 1'b1;
    #1;
    total++;
    if (bus.dataDrive !== 1'b1 || bus.dataOut !== 8'h00) begin
      bad++; $display("[TB] FAIL reset_status: got drive=%b data=%h expected drive=1 data=00", bus.dataDrive, bus.dataOut);
    end
    bus.addressbusLow = 8'h08;
    #1;
    total++;
    if (bus.dataOut !== 8'hFF) begin bad++; $display("[TB] FAIL reset_empty_data: got %h expected %h", bus.dataOut, 8'hFF); end
    bus.readEnable = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_scan();
    logic [3:0] exp;
    doReset();
    for (int i = 0; i < 8; i++) begin
      exp = 4'hF ^ (4'b0001 << (i % 4));
      total++;
      if (colOut !== exp) begin bad++; $display("[TB] FAIL scan_col%0d: got %b expected %b", i, colOut, exp); end
      repeat (SCAN_DIV) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_single_key();
    logic [7:0] d;
    logic dr;
    doReset();
    keyMask = 16'h0001 << 6;
    waitScans(3);
    keyMask = '0;
    busRead(16'h0108, d, dr);
    total++;
    if (dr !== 1'b0 || d !== 8'h00) begin bad++; $display("[TB] FAIL unmapped_read: got drive=%b data=%h expected drive=0 data=00", dr, d); end
    busRead(BASE + 16'd1, d, dr);
    total++;
    if (dr !== 1'b1 || d !== 8'h05) begin bad++; $display("[TB] FAIL single_status: got drive=%b data=%h expected drive=1 data=05", dr, d); end
    busRead(BASE, d, dr);
    total++;
    if (d !== 8'h06) begin bad++; $display("[TB] FAIL single_data: got %h expected %h", d, 8'h06); end
    busRead(BASE + 16'd1, d, dr);
    total++;
    if (d !== 8'h00) begin bad++; $display("[TB] FAIL single_status_after_pop: got %h expected %h", d, 8'h00); end
  endtask

  task automatic test_bounce();
    logic [7:0] d;
    logic dr;
    doReset();
    keyMask = 16'h0001;
    waitScans(1);
    keyMask = '0;
    waitScans(3);
    busRead(BASE + 16'd1, d, dr);
    total++;
    if (d !== 8'h00) begin bad++; $display("[TB] FAIL bounce_status: got %h expected %h", d, 8'h00); end
  endtask

  task automatic test_overflow();
    int codes[5];
    logic dup;
    logic [7:0] d;
    logic dr;
    for (int i = 0; i < 5; i++) begin
      do begin
        codes[i] = $urandom_range(0, 15);
        dup = 1'b0;
        for (int j = 0; j < i; j++) if (codes[j] == codes[i]) dup = 1'b1;
      end while (dup);
    end
    doReset();
    for (int i = 0; i < 5; i++) begin
      keyMask = 16'h0001 << codes[i];
      waitScans(2);
      keyMask = '0;
      waitScans(2);
    end
    busRead(BASE + 16'd1, d, dr);
    total++;
    if (d !== 8'h13) begin bad++; $display("[TB] FAIL ovf_status: got %h expected %h", d, 8'h13); end
    busRead(BASE + 16'd1, d, dr);
    total++;
    if (d !== 8'h11) begin bad++; $display("[TB] FAIL ovf_cleared: got %h expected %h", d, 8'h11); end
    for (int i = 0; i < 4; i++) begin
      busRead(BASE, d, dr);
      total++;
      if (d !== 8'(codes[i])) begin bad++; $display("[TB] FAIL ovf_data%0d: got %h expected %h", i, d, 8'(codes[i])); end
    end
    busRead(BASE, d, dr);
    total++;
    if (d !== 8'hFF) begin bad++; $display("[TB] FAIL ovf_empty_read: got %h expected %h", d, 8'hFF); end
  endtask

  task automatic test_multi();
    logic [7:0] d;
    logic dr;
    doReset();
    keyMask = (16'h0001 << 0) | (16'h0001 << 8);
    waitScans(4);
    busRead(BASE + 16'd1, d, dr);
    total++;
    if (d !== 8'h00) begin bad++; $display("[TB] FAIL multi_no_push: got %h expected %h", d, 8'h00); end
    keyMask = 16'h0001 << 5;
    waitScans(6);
    keyMask = '0;
    busRead(BASE + 16'd1, d, dr);
    total++;
    if (d !== 8'h05) begin bad++; $display("[TB] FAIL held_one_push: got %h expected %h", d, 8'h05); end
    busRead(BASE, d, dr);
    total++;
    if (d !== 8'h05) begin bad++; $display("[TB] FAIL held_code: got %h expected %h", d, 8'h05); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    logic dr;
    doReset();
    keyMask = 16'h0001 << 10;
    waitScans(1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    nrst = 1'b0;
    #1;
    total++;
    if (colOut !== 4'b1110) begin bad++; $display("[TB] FAIL midreset_col: got %b expected %b", colOut, 4'b1110); end
    bus.addressbusHigh = 8'h00;
    bus.addressbusLow  = 8'h09;
    bus.readEnable     = 1'b1;
    #1;
    total++;
    if (bus.dataOut !== 8'h00) begin bad++; $display("[TB] FAIL midreset_status: got %h expected %h", bus.dataOut, 8'h00); end
    bus.readEnable = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    waitScans(1);
    busRead(BASE + 16'd1, d, dr);
    total++;
    if (d !== 8'h00) begin bad++; $display("[TB] FAIL midreset_one_scan: got %h expected %h", d, 8'h00); end
    waitScans(1);
    busRead(BASE + 16'd1, d, dr);
    total++;
    if (d !== 8'h05) begin bad++; $display("[TB] FAIL midreset_pushed: got %h expected %h", d, 8'h05); end
    busRead(BASE, d, dr);
    total++;
    if (d !== 8'h0A) begin bad++; $display("[TB] FAIL midreset_code: got %h expected %h", d, 8'h0A); end
    keyMask = '0;
  endtask

  task automatic test_back_to_back();
    int a, b, c;
    logic [7:0] d;
    logic dr;
    a = $urandom_range(0, 15);
    do b = $urandom_range(0, 15); while (b == a);
    c = $urandom_range(0, 15);
    doReset();
    keyMask = 16'h0001 << a;
    waitScans(2);
    keyMask = '0;
    waitScans(2);
    keyMask = 16'h0001 << b;
    waitScans(1);
    alignLastCycle();
    busRead(BASE, d, dr);
    keyMask = '0;
    total++;
    if (d !== 8'(a)) begin bad++; $display("[TB] FAIL pushpop_old: got %h expected %h", d, 8'(a)); end
    busRead(BASE + 16'd1, d, dr);
    total++;
    if (d !== 8'h05) begin bad++; $display("[TB] FAIL pushpop_status: got %h expected %h", d, 8'h05); end
    busRead(BASE, d, dr);
    total++;
    if (d !== 8'(b)) begin bad++; $display("[TB] FAIL pushpop_new: got %h expected %h", d, 8'(b)); end
    waitScans(2);
    keyMask = 16'h0001 << c;
    waitScans(1);
    alignLastCycle();
    busRead(BASE, d, dr);
    keyMask = '0;
    total++;
    if (d !== 8'hFF) begin bad++; $display("[TB] FAIL pushpop_empty: got %h expected %h", d, 8'hFF); end
    busRead(BASE, d, dr);
    total++;
    if (d !== 8'(c)) begin bad++; $display("[TB] FAIL pushpop_empty_code: got %h expected %h", d, 8'(c)); end
  endtask

  task automatic test_random();
    logic [15:0] mask;
    logic [7:0]  d, exp;
    logic        dr;
    int          sel, hold, b1, b2;
    doReset();
    mq.delete();
    mOvf = 1'b0;
    mHeld = 1'b0;
    mStreak = 0;
    mCode = 0;
    for (int it = 0; it < 40; it++) begin
      sel = $urandom_range(0, 99);
      if (sel < 40) begin
        mask = '0;
      end else if (sel < 85) begin
        mask = 16'h0001 << $urandom_range(0, 15);
      end else begin
        b1 = $urandom_range(0, 15);
        do b2 = $urandom_range(0, 15); while (b2 == b1);
        mask = (16'h0001 << b1) | (16'h0001 << b2);
      end
      hold = $urandom_range(1, 3);
      keyMask = mask;
      for (int h = 0; h < hold; h++) begin
        if ($urandom_range(0, 3) == 0) begin
          busRead(BASE + 16'd1, d, dr);
          exp = 8'(mq.size() * 4 + (mOvf ? 2 : 0) + (mq.size() != 0 ? 1 : 0));
          mOvf = 1'b0;
          total++;
          if (d !== exp) begin bad++; $display("[TB] FAIL rand_status it%0d: got %h expected %h", it, d, exp); end
          if ($urandom_range(0, 1) == 1) begin
            busRead(BASE, d, dr);
            exp = (mq.size() != 0) ? 8'(mq.pop_front()) : 8'hFF;
            total++;
            if (d !== exp) begin bad++; $display("[TB] FAIL rand_data it%0d: got %h expected %h", it, d, exp); end
          end
        end
        waitScans(1);
        modelScan(mask);
      end
    end
    keyMask = '0;
    busRead(BASE + 16'd1, d, dr);
    exp = 8'(mq.size() * 4 + (mOvf ? 2 : 0) + (mq.size() != 0 ? 1 : 0));
    total++;
    if (d !== exp) begin bad++; $display("[TB] FAIL rand_final_status: got %h expected %h", d, exp); end
    for (int i = 0; i < 5; i++) begin
      busRead(BASE, d, dr);
      exp = (mq.size() != 0) ? 8'(mq.pop_front()) : 8'hFF;
      total++;
      if (d !== exp) begin bad++; $display("[TB] FAIL rand_drain%0d: got %h expected %h", i, d, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_single_key();
    test_bounce();
    test_overflow();
    test_multi();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
